vga_sync_tracker: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 16 +
 rtl/vga_sync_tracker_if.sv | 31 +++
 rtl/vga_sync_tracker_sync_edge_detect.sv | 25 ++
 rtl/vga_sync_tracker.sv | 146 ++++++++++++++
 tb/tb_vga_sync_tracker.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and lock-FSM state encoding.
package vga_timing_pkg;

  // 640x480@60 geometry, blanking included in the totals
  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } lock_state_t;

endpackage

// File: rtl/vga_sync_tracker_if.sv
// Bundle of raw sync inputs and tracked timing outputs.
// master: timing source / pixel consumer side. slave: the tracker.
interface vga_sync_tracker_if #(
  parameter int COL_W   = 10,
  parameter int ROW_W   = 10,
  parameter int FRAME_W = 8
);
  logic               vgahsync;
  logic               vgavsync;
  logic               ohsync;
  logic               ovsync;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic               active;
  logic               locked;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_count;
  logic               sync_err;

  modport master (
    output vgahsync, vgavsync,
    input  ohsync, ovsync, col, row, active, locked,
           frame_start, frame_count, sync_err
  );

  modport slave (
    input  vgahsync, vgavsync,
    output ohsync, ovsync, col, row, active, locked,
           frame_start, frame_count, sync_err
  );
endinterface

// File: rtl/vga_sync_tracker_sync_edge_detect.sv
// Polarity-aware sync register with combinational leading-edge detect.
// lead_edge looks at the raw input against the registered copy, so it is
// valid in the same cycle the new level arrives.
module sync_edge_detect #(
  parameter bit ACTIVE_HIGH = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic sync_in,
  output logic sync_q,
  output logic lead_edge
);
  logic now_level;
  logic prev_level;

  // One-clock delayed copy of the raw sync
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= 1'b0;
    else       sync_q <= sync_in;
  end

  assign now_level  = sync_in ~^ ACTIVE_HIGH;
  assign prev_level = sync_q  ~^ ACTIVE_HIGH;
  assign lead_edge  = now_level & ~prev_level;
endmodule

// File: rtl/vga_sync_tracker.sv
// Sync-to-count tracker: realigns col/row on each vsync leading edge,
// checks frame geometry and reports lock, active video and frame events.
module vga_sync_tracker
  import vga_timing_pkg::*;
#(
  parameter int TOTAL_COLS        = H_TOTAL,
  parameter int TOTAL_ROWS        = V_TOTAL,
  parameter int ACTIVE_COLS       = H_ACTIVE,
  parameter int ACTIVE_ROWS       = V_ACTIVE,
  parameter int COL_W             = 10,
  parameter int ROW_W             = 10,
  parameter bit VSYNC_ACTIVE_HIGH = 1'b1,
  parameter int LOCK_FRAMES       = 2,
  parameter int FRAME_W           = 8
) (
  input  logic          clock,
  input  logic          reset,
  vga_sync_tracker_if.slave bus
);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(TOTAL_COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(TOTAL_ROWS - 1);
  localparam logic [COL_W-1:0] COL_VIS  = COL_W'(ACTIVE_COLS);
  localparam logic [ROW_W-1:0] ROW_VIS  = ROW_W'(ACTIVE_ROWS);
  localparam logic [3:0]       LOCK_N   = 4'(LOCK_FRAMES);

  logic               vs_edge;
  logic               ovsync;
  logic               ohsync_reg;
  logic [COL_W-1:0]   col_reg, col_next;
  logic [ROW_W-1:0]   row_reg, row_next;
  lock_state_t        state_reg, state_next;
  logic [3:0]         good_reg, good_next;
  logic               err_next;
  logic               at_end, good_edge, bad_edge, missed_edge;
  logic               locked_reg, active_reg, frame_start_reg, sync_err_reg;
  logic [FRAME_W-1:0] frame_count_reg;

  sync_edge_detect #(.ACTIVE_HIGH(VSYNC_ACTIVE_HIGH)) u_vs_edge (
    .clock     (clock),
    .reset     (reset),
    .sync_in   (bus.vgavsync),
    .sync_q    (ovsync),
    .lead_edge (vs_edge)
  );

  // hsync is only delayed; line alignment comes from vsync and TOTAL_COLS
  always_ff @(posedge clock or posedge reset) begin
    if (reset) ohsync_reg <= 1'b0;
    else       ohsync_reg <= bus.vgahsync;
  end

  assign at_end      = (col_reg == COL_LAST) && (row_reg == ROW_LAST);
  assign good_edge   = vs_edge & at_end;
  assign bad_edge    = vs_edge & ~at_end;
  assign missed_edge = at_end & ~vs_edge;

  // Next counter position: edge realigns, otherwise free-run with wrap
  always_comb begin
    col_next = col_reg + 1'b1;
    row_next = row_reg;
    if (vs_edge) begin
      col_next = '0;
      row_next = '0;
    end else if (col_reg == COL_LAST) begin
      col_next = '0;
      row_next = (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
    end
  end

  // Lock FSM next state: count consecutive good frames, drop on any error
  always_comb begin
    state_next = state_reg;
    good_next  = good_reg;
    err_next   = 1'b0;
    unique case (state_reg)
      SEARCH: begin
        if (vs_edge) begin
          state_next = ACQUIRE;
          good_next  = '0;
        end
      end
      ACQUIRE: begin
        if (good_edge) begin
          good_next = good_reg + 4'd1;
          if (good_reg + 4'd1 == LOCK_N) state_next = LOCKED;
        end else if (bad_edge || missed_edge) begin
          good_next = '0;
          err_next  = 1'b1;
        end
      end
      LOCKED: begin
        if (bad_edge || missed_edge) begin
          state_next = ACQUIRE;
          good_next  = '0;
          err_next   = 1'b1;
        end
      end
      default: begin
        state_next = SEARCH;
        good_next  = '0;
      end
    endcase
  end

  // Lock FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= SEARCH;
      good_reg  <= '0;
    end else begin
      state_reg <= state_next;
      good_reg  <= good_next;
    end
  end

  // Counters and registered status outputs, all aligned with col/row
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_reg         <= '0;
      row_reg         <= '0;
      locked_reg      <= 1'b0;
      active_reg      <= 1'b0;
      frame_start_reg <= 1'b0;
      frame_count_reg <= '0;
      sync_err_reg    <= 1'b0;
    end else begin
      col_reg         <= col_next;
      row_reg         <= row_next;
      locked_reg      <= (state_next == LOCKED);
      active_reg      <= (state_next == LOCKED) && (col_next < COL_VIS) && (row_next < ROW_VIS);
      frame_start_reg <= vs_edge;
      if (vs_edge) frame_count_reg <= frame_count_reg + 1'b1;
      sync_err_reg    <= err_next;
    end
  end

  assign bus.ohsync      = ohsync_reg;
  assign bus.ovsync      = ovsync;
  assign bus.col         = col_reg;
  assign bus.row         = row_reg;
  assign bus.active      = active_reg;
  assign bus.locked      = locked_reg;
  assign bus.frame_start = frame_start_reg;
  assign bus.frame_count = frame_count_reg;
  assign bus.sync_err    = sync_err_reg;
endmodule

// File: tb/tb_vga_sync_tracker.sv
// Scoreboard bench: a positional frame model predicts every cycle's outputs
// for an active-high and an active-low tracker driven by the same logical vsync.
module tb_vga_sync_tracker;
  localparam int TC = 10, TR = 6, AC = 8, AR = 4, LOCKN = 2, FW = 8;
  localparam int FRAME = TC * TR;

  typedef struct {
    int   cyc;
    logic ohs, ovs_hi, ovs_lo;
    int   col, row;
    logic act, lck, fs, err;
    int   fc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic vs = 1'b0, hs = 1'b0;

  vga_sync_tracker_if #(.COL_W(4), .ROW_W(3), .FRAME_W(FW)) bus_hi ();
  vga_sync_tracker_if #(.COL_W(4), .ROW_W(3), .FRAME_W(FW)) bus_lo ();

  assign bus_hi.vgavsync = vs;
  assign bus_hi.vgahsync = hs;
  assign bus_lo.vgavsync = ~vs;
  assign bus_lo.vgahsync = hs;

  vga_sync_tracker #(
    .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
    .COL_W(4), .ROW_W(3), .VSYNC_ACTIVE_HIGH(1'b1), .LOCK_FRAMES(LOCKN), .FRAME_W(FW)
  ) dut_hi (.clock(clock), .reset(reset), .bus(bus_hi));

  vga_sync_tracker #(
    .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
    .COL_W(4), .ROW_W(3), .VSYNC_ACTIVE_HIGH(1'b0), .LOCK_FRAMES(LOCKN), .FRAME_W(FW)
  ) dut_lo (.clock(clock), .reset(reset), .bus(bus_lo));

  always #5 clock = ~clock;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  exp_t exp_q[$];

  // Reference model: position within the frame since the last leading edge,
  // lock mode 0=searching 1=acquiring 2=locked, and a good-frame streak.
  int   m_pos = 0, m_mode = 0, m_streak = 0, m_fc = 0;
  logic m_prev = 1'b0;

  function automatic exp_t zero_exp();
    exp_t e;
    e.cyc = cyc; e.ohs = 0; e.ovs_hi = 0; e.ovs_lo = 0;
    e.col = 0; e.row = 0; e.act = 0; e.lck = 0; e.fs = 0; e.err = 0; e.fc = 0;
    return e;
  endfunction

  task automatic model_reset();
    m_pos = 0; m_mode = 0; m_streak = 0; m_fc = 0; m_prev = 1'b0;
  endtask

  function automatic exp_t model_step(input logic v, input logic h);
    exp_t e;
    logic edge_seen, end_seen, good, bad, miss;
    e = zero_exp();
    edge_seen = v & ~m_prev;
    end_seen  = (m_pos == FRAME - 1);
    good = edge_seen & end_seen;
    bad  = edge_seen & ~end_seen;
    miss = end_seen & ~edge_seen;
    m_pos = edge_seen ? 0 : (m_pos + 1) % FRAME;
    if (edge_seen) m_fc = (m_fc + 1) % (1 << FW);
    case (m_mode)
      0: if (edge_seen) begin m_mode = 1; m_streak = 0; end
      1: if (good) begin
           m_streak++;
           if (m_streak == LOCKN) m_mode = 2;
         end else if (bad || miss) begin
           m_streak = 0; e.err = 1;
         end
      default: if (bad || miss) begin m_mode = 1; m_streak = 0; e.err = 1; end
    endcase
    m_prev   = v;
    e.ohs    = h;
    e.ovs_hi = v;
    e.ovs_lo = ~v;
    e.col    = m_pos % TC;
    e.row    = m_pos / TC;
    e.fs     = edge_seen;
    e.fc     = m_fc;
    e.lck    = (m_mode == 2);
    e.act    = (m_mode == 2) && (e.col < AC) && (e.row < AR);
    return e;
  endfunction

  task automatic cmp(input string nm, input exp_t e, input logic ovs_e,
                     input logic ohs, input logic ovs, input int col, input int row,
                     input logic act, input logic lck, input logic fs, input int fc,
                     input logic err);
    n_cmp++;
    if (ohs !== e.ohs || ovs !== ovs_e || col != e.col || row != e.row ||
        act !== e.act || lck !== e.lck || fs !== e.fs || fc != e.fc || err !== e.err) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got hs=%b vs=%b col=%0d row=%0d act=%b lck=%b fs=%b fc=%0d err=%b want hs=%b vs=%b col=%0d row=%0d act=%b lck=%b fs=%b fc=%0d err=%b",
               nm, e.cyc, ohs, ovs, col, row, act, lck, fs, fc, err,
               e.ohs, ovs_e, e.col, e.row, e.act, e.lck, e.fs, e.fc, e.err);
    end
  endtask

  task automatic check_both(input string tag, input exp_t e);
    cmp({tag, "_hi"}, e, e.ovs_hi, bus_hi.ohsync, bus_hi.ovsync, int'(bus_hi.col), int'(bus_hi.row),
        bus_hi.active, bus_hi.locked, bus_hi.frame_start, int'(bus_hi.frame_count), bus_hi.sync_err);
    cmp({tag, "_lo"}, e, e.ovs_lo, bus_lo.ohsync, bus_lo.ovsync, int'(bus_lo.col), int'(bus_lo.row),
        bus_lo.active, bus_lo.locked, bus_lo.frame_start, int'(bus_lo.frame_count), bus_lo.sync_err);
  endtask

  // Monitor: one expected record per clock, compared just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_both("cycle", e);
        if (bus_hi.frame_start)
          $display("frame_start cyc=%0d frame_count=%0d locked=%b", e.cyc, bus_hi.frame_count, bus_hi.locked);
      end
    end
  end

  // One clock of stimulus; expectation pushed before the sampling edge
  task automatic step(input logic r, input logic v);
    @(negedge clock);
    cyc++;
    reset = r;
    vs    = v;
    hs    = 1'($urandom_range(0, 1));
    if (r) begin
      model_reset();
      exp_q.push_back(zero_exp());
    end else begin
      exp_q.push_back(model_step(v, hs));
    end
  endtask

  task automatic frame(input int len);
    for (int i = 0; i < len; i++) step(1'b0, i < 3);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  // Reset asserted between clock edges must clear outputs immediately
  task automatic async_reset();
    exp_t z;
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    z = zero_exp();
    check_both("async_reset", z);
    cyc++;
    model_reset();
    exp_q.push_back(zero_exp());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t z;
    repeat (3) step(1'b1, 1'b0);
    idle($urandom_range(1, 59));
    repeat (5) frame(60);                  // acquire then lock
    frame(45);                             // short frame -> error, unlock
    repeat (4) frame(60);                  // relock
    idle(120);                             // vsync missing while locked
    repeat (4) frame(60);                  // relock
    for (int i = 0; i < 25; i++) step(1'b0, i < 3);  // stop at col 4, row 2
    async_reset();
    repeat (2) step(1'b1, 1'b0);
    idle($urandom_range(1, 59));
    repeat (258) frame(60);                // frame_count wraps past 255
    idle(3);
    @(negedge clock);
    @(negedge clock);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
